axis_ps2_tx: RTL



---
 rtl/axis_ps2_tx_if.sv | 9 +
 rtl/axis_ps2_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axis_ps2_tx_if.sv
// AXI-stream byte channel feeding the PS/2 host-to-device transmitter.
interface axis_ps2_tx_if;
   logic       tvalid;
   logic       tready;
   logic [7:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_ps2_tx.sv
// PS/2 host-to-device frame transmitter with an AXI-stream byte input and open-drain pin enables.
// Optional PS2_TX_FILTER_EN adds an 8-sample stability filter on the synced PS/2 clock.
module axis_ps2_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   axis_ps2_tx_if.slave s_axis,
   input  logic         ps2_clk_i,
   input  logic         ps2_data_i,
   output logic         ps2_clk_oe_o,
   output logic         ps2_data_oe_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned WDG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [WDG_W-1:0] WDG_MAX  = WDG_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, WAIT_REL} state_t;

   logic clk_meta, clk_sync, data_meta, data_sync;
   logic clk_lvl, clk_prev, fall;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         {clk_meta, clk_sync, data_meta, data_sync} <= '0;
      end else begin
         clk_meta  <= ps2_clk_i;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data_i;
         data_sync <= data_meta;
      end
   end

`ifdef PS2_TX_FILTER_EN
   logic [2:0] stab_cnt;

   // Level follows the synced clock only after 8 consecutive differing samples.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_lvl  <= 1'b0;
         stab_cnt <= '0;
      end else if (clk_sync == clk_lvl) begin
         stab_cnt <= '0;
      end else if (stab_cnt == 3'd7) begin
         clk_lvl  <= clk_sync;
         stab_cnt <= '0;
      end else begin
         stab_cnt <= stab_cnt + 3'd1;
      end
   end
`else
   assign clk_lvl = clk_sync;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) clk_prev <= 1'b0;
      else       clk_prev <= clk_lvl;
   end

   assign fall = clk_prev & ~clk_lvl;

   state_t           state;
   logic [7:0]       data_q;
   logic             parity_q;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic [WDG_W-1:0] wdog;
   logic             tready_q;

   assign s_axis.tready = tready_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         data_q        <= '0;
         parity_q      <= 1'b0;
         bit_cnt       <= '0;
         inh_cnt       <= '0;
         wdog          <= '0;
         tready_q      <= 1'b0;
         ps2_clk_oe_o  <= 1'b0;
         ps2_data_oe_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               tready_q <= 1'b1;
               if (s_axis.tvalid && tready_q) begin
                  data_q        <= s_axis.tdata;
                  parity_q      <= ~^s_axis.tdata;
                  bit_cnt       <= '0;
                  inh_cnt       <= '0;
                  tready_q      <= 1'b0;
                  busy_o        <= 1'b1;
                  ps2_clk_oe_o  <= 1'b1;
                  ps2_data_oe_o <= (INHIBIT_CYCLES == 1);
                  state         <= INHIBIT;
               end
            end
            INHIBIT: begin
               inh_cnt <= inh_cnt + INH_W'(1);
               // Start bit is pulled one cycle early so it overlaps the last inhibit cycle.
               if (inh_cnt == INH_PRE) ps2_data_oe_o <= 1'b1;
               if (inh_cnt == INH_LAST) begin
                  ps2_clk_oe_o  <= 1'b0;
                  ps2_data_oe_o <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               wdog  <= '0;
               state <= XFER;
            end
            XFER: begin
               if (fall) begin
                  wdog    <= '0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt < 4'd8) begin
                     ps2_data_oe_o <= ~data_q[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                     ps2_data_oe_o <= ~parity_q;
                  end else if (bit_cnt == 4'd9) begin
                     ps2_data_oe_o <= 1'b0;
                  end else begin
                     done_o <= ~data_sync;
                     err_o  <= data_sync;
                     state  <= WAIT_REL;
                  end
               end else if (wdog == WDG_MAX) begin
                  ps2_clk_oe_o  <= 1'b0;
                  ps2_data_oe_o <= 1'b0;
                  err_o         <= 1'b1;
                  state         <= WAIT_REL;
               end else begin
                  wdog <= wdog + WDG_W'(1);
               end
            end
            WAIT_REL: begin
               ps2_clk_oe_o  <= 1'b0;
               ps2_data_oe_o <= 1'b0;
               if (clk_sync && data_sync) begin
                  busy_o   <= 1'b0;
                  tready_q <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
